// File: rtl/image_pkg.sv
// Shared image ROM geometry, channel encoding, fetcher states and plane base helper.
package image_pkg;

    localparam int IMG_PIXELS = 10000;
    localparam int NUM_IMAGES = 4;

    typedef enum logic [1:0] {
        CH_R = 2'd0,
        CH_G = 2'd1,
        CH_B = 2'd2
    } chan_e;

    typedef logic [1:0] state_t;

    localparam state_t IDLE   = 2'd0;
    localparam state_t FETCH  = 2'd1;
    localparam state_t DRAIN  = 2'd2;
    localparam state_t FINISH = 2'd3;

    // Planes are laid out channel-major: (chan*NUM_IMAGES + img) * pixels.
    function automatic logic [16:0] plane_base(
        input logic [1:0] img,
        input logic [1:0] chan,
        input int         pixels
    );
        int unsigned idx;
        idx = {28'd0, chan, img};
        return 17'(idx * pixels);
    endfunction

endpackage

// File: rtl/image_vector_fetcher_fifo.sv
// Synchronous FIFO for fetched pixel quads; entry = {last, data}.
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 33,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push_ok && !pop_ok) begin
                count <= count + 1'b1;
            end else if (pop_ok && !push_ok) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/image_vector_fetcher.sv
// Streams one colour plane from the image ROM as packed 4-pixel quads.
// Optional plane checksum accumulator: IMAGE_FETCH_CHECKSUM_EN.
module image_vector_fetcher #(
    parameter int IMG_PIXELS = 10000,
    parameter int FIFO_DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [1:0]   img_sel,
    input  logic [1:0]   chan_sel,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [127:0] rom_addr,
    input  logic [127:0] rom_rd,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [31:0]  out_data,
    output logic         out_last,
    output logic [23:0]  checksum
);
    import image_pkg::*;

    localparam int W  = IMG_PIXELS / 4;
    localparam int IW = $clog2(W + 1);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_t        state;
    logic [16:0]   addr_q;
    logic [16:0]   next_addr;
    logic [IW-1:0] issued;
    logic          inflight;
    logic          cap_last;
    logic          err_q;
    logic [CW-1:0] count;
    logic          empty;
    logic          full;
    logic          pop;
    logic          issue;
    logic          last_word;
    logic          illegal;
    logic [31:0]   quad;
    logic [32:0]   head;
    logic          unused_rd;

    assign illegal   = (chan_sel > 2'(CH_B));
    assign pop       = out_valid && out_ready;
    assign last_word = (issued == IW'(W - 1));
    // A pop this cycle frees a slot for an issue this cycle.
    assign issue     = (state == FETCH) &&
                       ((int'(count) + int'(inflight)) <
                        (FIFO_DEPTH + int'(pop)));

    assign quad      = {rom_rd[103:96], rom_rd[71:64],
                        rom_rd[39:32], rom_rd[7:0]};
    assign unused_rd = ^{rom_rd[127:104], rom_rd[95:72],
                         rom_rd[63:40], rom_rd[31:8], full};

    assign rom_addr  = {111'd0, addr_q};
    assign busy      = (state != IDLE);
    assign done      = (state == FINISH);
    assign err       = done && err_q;
    assign out_valid = !empty;
    assign out_data  = head[31:0];
    assign out_last  = head[32];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            addr_q    <= '0;
            next_addr <= '0;
            issued    <= '0;
            inflight  <= 1'b0;
            cap_last  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                addr_q    <= next_addr;
                next_addr <= next_addr + 17'd4;
                cap_last  <= last_word;
                issued    <= issued + 1'b1;
            end
            unique case (state)
                IDLE: begin
                    if (start) begin
                        next_addr <= plane_base(img_sel, chan_sel,
                                                IMG_PIXELS);
                        issued    <= '0;
                        err_q     <= illegal;
                        // Illegal requests pass through an empty drain
                        // so done/err land one cycle after start.
                        state     <= illegal ? DRAIN : FETCH;
                    end
                end
                FETCH: begin
                    if (issue && last_word) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!inflight && empty) begin
                        state <= FINISH;
                    end
                end
                FINISH: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (33),
        .CW    (CW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (inflight),
        .din   ({cap_last, quad}),
        .pop   (pop),
        .dout  (head),
        .count (count),
        .empty (empty),
        .full  (full)
    );

`ifdef IMAGE_FETCH_CHECKSUM_EN
    logic [23:0] sum_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q <= '0;
        end else if (state == IDLE && start) begin
            sum_q <= '0;
        end else if (pop) begin
            sum_q <= sum_q + 24'(out_data[7:0])
                           + 24'(out_data[15:8])
                           + 24'(out_data[23:16])
                           + 24'(out_data[31:24]);
        end
    end

    assign checksum = sum_q;
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_image_vector_fetcher.sv
// Self-checking bench for image_vector_fetcher with a negedge-registered ROM model.
module tb_image_vector_fetcher;

    localparam int W     = 2500;
    localparam int LIMIT = 20000;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [1:0]   img_sel;
    logic [1:0]   chan_sel;
    logic         busy;
    logic         done;
    logic         err;
    logic [127:0] rom_addr;
    logic [127:0] rom_rd;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  out_data;
    logic         out_last;
    logic [23:0]  checksum;

    int passed = 0;
    int total  = 0;
    int rom_mode = 0;

    logic [32:0] sbq [$];

    typedef struct {
        logic [1:0]  img;
        logic [1:0]  chan;
        bit          exp_err;
        logic [16:0] first_a;
        logic [16:0] last_a;
        int          done_cyc;
    } vec_t;

    vec_t tbl [6];

    always #5 clk = ~clk;

    image_vector_fetcher #(
        .IMG_PIXELS (10000),
        .FIFO_DEPTH (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .img_sel   (img_sel),
        .chan_sel  (chan_sel),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .rom_addr  (rom_addr),
        .rom_rd    (rom_rd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .checksum  (checksum)
    );

    function automatic logic [7:0] pix(input int a);
        return (rom_mode == 1) ? 8'hFF : 8'(a);
    endfunction

    always @(negedge clk) begin
        rom_rd <= {24'd0, pix(int'(rom_addr[16:0]) + 3),
                   24'd0, pix(int'(rom_addr[16:0]) + 2),
                   24'd0, pix(int'(rom_addr[16:0]) + 1),
                   24'd0, pix(int'(rom_addr[16:0]))};
    end

    task automatic check(input string name,
                         input logic [127:0] act,
                         input logic [127:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_valid"}, out_valid, 0);
        check({tag, "_last"}, out_last, 0);
        check({tag, "_data"}, out_data, 0);
        check({tag, "_addr"}, rom_addr, 0);
        check({tag, "_cksum"}, checksum, 0);
    endtask

    task automatic run_xfer(input logic [1:0] img,
                            input logic [1:0] chan,
                            input bit exp_err,
                            input logic [16:0] first_a,
                            input logic [16:0] last_a,
                            input int done_cyc,
                            input int duty,
                            input int abort_at);
        int          c;
        int          popped;
        bit          seen_done;
        bit          occ_bad;
        bit          hold_bad;
        logic        pv;
        logic        pr;
        logic [32:0] pd;
        logic [32:0] e;
        logic [16:0] addr0;
        logic [23:0] sum;

        sbq.delete();
        sum = 0; popped = 0; seen_done = 0;
        occ_bad = 0; hold_bad = 0; pv = 0; pr = 0; pd = 0;
        addr0 = rom_addr[16:0];
        if (!exp_err) begin
            for (int k = 0; k < W; k++) begin
                int          a;
                logic [31:0] q;
                a = int'(first_a) + 4 * k;
                q = {pix(a + 3), pix(a + 2), pix(a + 1), pix(a)};
                sbq.push_back({(k == W - 1), q});
            end
        end

        start = 1'b1; img_sel = img; chan_sel = chan;
        @(posedge clk); #1;
        start = 1'b0;
        img_sel = 2'($urandom);
        chan_sel = 2'($urandom);
        c = 0;
        check("cksum_clear", checksum, 0);

        while (c < LIMIT) begin
            if (abort_at >= 0 && popped == abort_at) begin
                rst = 1'b1;
                @(posedge clk); #1;
                check_idle_outputs("abort");
                rst = 1'b0;
                sbq.delete();
                return;
            end
            if (c == 1 && !exp_err) check("first_addr", rom_addr, first_a);
            if (c == 2 && !exp_err) check("first_valid", out_valid, 1);
            if (int'(dut.u_fifo.count) + int'(dut.inflight) > 4) occ_bad = 1;
            if (pv && !pr && (!out_valid || {out_last, out_data} != pd))
                hold_bad = 1;
            out_ready = ($urandom_range(99) < duty);
            pv = out_valid; pr = out_ready; pd = {out_last, out_data};
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    total++;
                    $display("FAIL extra_quad: got %h, expected no quad",
                             {out_last, out_data});
                end else begin
                    e = sbq.pop_front();
                    check("quad", {out_last, out_data}, e);
                    sum = sum + 24'(e[7:0]) + 24'(e[15:8])
                              + 24'(e[23:16]) + 24'(e[31:24]);
                    popped++;
                end
            end
            if (done) begin
                seen_done = 1;
                break;
            end
            @(posedge clk); #1;
            c++;
        end

        if (!seen_done) begin
            total++;
            $display("FAIL done_timeout: got no done after %0d cycles, expected done", c);
        end else begin
            if (duty == 100) check("done_cycle", c, done_cyc);
            check("err", err, exp_err);
            check("lost_quads", sbq.size(), 0);
            if (exp_err) check("addr_hold", rom_addr, addr0);
            else check("last_addr", rom_addr, last_a);
            check("occupancy_ok", occ_bad, 0);
            check("stall_hold_ok", hold_bad, 0);
`ifdef IMAGE_FETCH_CHECKSUM_EN
            check("checksum", checksum, sum);
`else
            check("checksum", checksum, 0);
`endif
            @(posedge clk); #1;
            check("idle_after_done", {busy, done, err}, 0);
        end
    endtask

    initial begin
        tbl[0] = '{2'd0, 2'd0, 1'b0, 17'd0,      17'd9996,   2503};
        tbl[1] = '{2'd3, 2'd2, 1'b0, 17'd110000, 17'd119996, 2503};
        tbl[2] = '{2'd1, 2'd1, 1'b0, 17'd50000,  17'd59996,  2503};
        tbl[3] = '{2'd2, 2'd0, 1'b0, 17'd20000,  17'd29996,  2503};
        tbl[4] = '{2'd0, 2'd3, 1'b1, 17'd0,      17'd0,      1};
        tbl[5] = '{2'd3, 2'd3, 1'b1, 17'd0,      17'd0,      1};

        rst = 1'b1; start = 1'b0; out_ready = 1'b0;
        img_sel = 2'd0; chan_sel = 2'd0;
        repeat (2) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) begin
            run_xfer(tbl[i].img, tbl[i].chan, tbl[i].exp_err,
                     tbl[i].first_a, tbl[i].last_a, tbl[i].done_cyc,
                     100, -1);
        end

        run_xfer(2'd1, 2'd2, 1'b0, 17'd90000, 17'd99996, 0, 30, -1);

        run_xfer(2'd2, 2'd1, 1'b0, 17'd60000, 17'd69996, 2503, 100, 1000);
        run_xfer(2'd2, 2'd1, 1'b0, 17'd60000, 17'd69996, 2503, 100, -1);

        rom_mode = 1;
        run_xfer(2'd0, 2'd0, 1'b0, 17'd0, 17'd9996, 2503, 100, -1);
`ifdef IMAGE_FETCH_CHECKSUM_EN
        check("cksum_ff_plane", checksum, 24'h26E8F0);
`else
        check("cksum_ff_plane", checksum, 0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
